// File: rtl/req_rr_arbiter_if.sv
// Request/response bundle for req_rr_arbiter: NUM_REQ packed upstream channels
// plus one shared downstream channel. The arbiter takes the slave modport.
interface req_rr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            i_req_command;
  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;

  logic                  o_out_valid;
  logic                  i_out_ready;
  logic                  o_out_command;
  logic [ADDR_WIDTH-1:0] o_out_address;
  logic [DATA_WIDTH-1:0] o_out_data;
  logic [ID_WIDTH-1:0]   o_out_id;

  modport slave (
    input  i_req_valid, i_req_command, i_req_address, i_req_data, i_out_ready,
    output o_req_ready, o_out_valid, o_out_command, o_out_address, o_out_data, o_out_id
  );

  modport master (
    output i_req_valid, i_req_command, i_req_address, i_req_data, i_out_ready,
    input  o_req_ready, o_out_valid, o_out_command, o_out_address, o_out_data, o_out_id
  );
endinterface

// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter of NUM_REQ requesters into one registered output slot.
// Define REQ_RR_ARBITER_READ_PRIORITY_EN to serve pending READs ahead of WRITEs.
module req_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  req_rr_arbiter_if.slave  bus
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(NUM_REQ - 1);

  logic [ADDR_WIDTH-1:0] req_addr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];

  logic                  out_valid;
  logic                  out_command;
  logic [ADDR_WIDTH-1:0] out_address;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_id;
  logic [ID_WIDTH-1:0]   last_grant;

  logic                  slot_free;
  logic [NUM_REQ-1:0]    eligible;
  logic [ID_WIDTH-1:0]   sel;
  logic [ID_WIDTH-1:0]   cand;
  logic                  found;
  logic                  grant;
  logic [NUM_REQ-1:0]    ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = bus.i_req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data[g] = bus.i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign slot_free = !out_valid || bus.i_out_ready;

`ifdef REQ_RR_ARBITER_READ_PRIORITY_EN
  logic [NUM_REQ-1:0] read_pending;
  assign read_pending = bus.i_req_valid & bus.i_req_command;
  // WRITEs compete only when no READ is waiting.
  assign eligible     = (|read_pending) ? read_pending : bus.i_req_valid;
`else
  assign eligible = bus.i_req_valid;
`endif

  // Scan last_grant+1 .. last_grant+NUM_REQ with an explicit wrap so a
  // non-power-of-two NUM_REQ never produces an out-of-range index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    found = 1'b0;
    sel   = '0;
    cand  = last_grant;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + ID_WIDTH'(1);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign grant = slot_free && found && !i_rst;

  always_comb begin
    ready = '0;
    if (grant) ready[sel] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: payload registers are reset too, so a discarded entry reads back as zero.
      out_valid   <= 1'b0;
      out_command <= 1'b0;
      out_address <= '0;
      out_data    <= '0;
      out_id      <= '0;
      last_grant  <= LAST_IDX;
    end else if (grant) begin
      out_valid   <= 1'b1;
      out_command <= bus.i_req_command[sel];
      out_address <= req_addr[sel];
      out_data    <= req_data[sel];
      out_id      <= sel;
      last_grant  <= sel;
    end else if (bus.i_out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign bus.o_req_ready   = ready;
  assign bus.o_out_valid   = out_valid;
  assign bus.o_out_command = out_command;
  assign bus.o_out_address = out_address;
  assign bus.o_out_data    = out_data;
  assign bus.o_out_id      = out_id;

endmodule

// File: tb/tb_req_rr_arbiter.sv
// Self-checking bench for req_rr_arbiter: directed scenarios plus randomized
// traffic against a behavioural round-robin model (three requesters).
module tb_req_rr_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 2;
  localparam int OW = 1 + 1 + IW + AW + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]  valid;
  logic [N-1:0]  cmd;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] data [N];
  logic          out_ready;

  req_rr_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  req_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  assign bus.i_req_valid   = valid;
  assign bus.i_req_command = cmd;
  assign bus.i_out_ready   = out_ready;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.i_req_address[i*AW +: AW] = addr[i];
      bus.i_req_data[i*DW +: DW]    = data[i];
    end
  end

  wire [OW-1:0] out_bundle = {bus.o_out_valid, bus.o_out_command, bus.o_out_id,
                              bus.o_out_address, bus.o_out_data};

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: pointer as a plain integer, output slot as loose variables.
  int            m_ptr;
  logic          m_valid;
  logic          m_cmd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_id;

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] elig;
    logic [N-1:0] r;
    r = '0;
    if (rst || (m_valid && !out_ready)) return r;
    elig = valid;
`ifdef REQ_RR_ARBITER_READ_PRIORITY_EN
    if ((valid & cmd) != '0) elig = valid & cmd;
`endif
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (elig[i]) begin
        r[i] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] model_bundle();
    return {m_valid, m_cmd, IW'(m_id), m_addr, m_data};
  endfunction

  // Advances one clock, updating the model from the inputs seen before the edge.
  task automatic clock_edge();
    logic [N-1:0] r;
    int idx;
    r = exp_ready();
    idx = -1;
    for (int i = 0; i < N; i++) if (r[i]) idx = i;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_cmd = 1'b0; m_addr = '0; m_data = '0; m_id = 0; m_ptr = N - 1;
    end else if (idx >= 0) begin
      m_valid = 1'b1; m_cmd = cmd[idx]; m_addr = addr[idx]; m_data = data[idx];
      m_id = idx; m_ptr = idx;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '1; out_ready = 1'b0; cmd = '0;
    for (int i = 0; i < N; i++) begin addr[i] = AW'(i + 1); data[i] = DW'(i + 1); end
    clock_edge();
    clock_edge();
    vectors++;
    if (bus.o_req_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 000", bus.o_req_ready);
    end
    vectors++;
    if (out_bundle !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", out_bundle);
    end
    rst = 1'b0; valid = '0;
    #1;
  endtask

  task automatic test_single();
    valid = 3'b001; cmd = 3'b000; addr[0] = 8'h10; data[0] = 32'hDEADBEEF; out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL single_ready: got %b want 001", bus.o_req_ready);
    end
    clock_edge();
    valid = '0;
    vectors++;
    if (out_bundle !== {1'b1, 1'b0, 2'd0, 8'h10, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL single_out: got %h want %h", out_bundle, {1'b1, 1'b0, 2'd0, 8'h10, 32'hDEADBEEF});
    end
    clock_edge();
    vectors++;
    if (bus.o_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got valid %b want 0", bus.o_out_valid);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    valid = 3'b011; cmd = '0; addr[0] = 8'h01; addr[1] = 8'h02; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] want_rdy;
      want_rdy = (k % 2 == 0) ? 3'b001 : 3'b010;
      #1;
      vectors++;
      if (bus.o_req_ready !== want_rdy) begin
        miscompares++;
        $display("FAIL alternate_ready[%0d]: got %b want %b", k, bus.o_req_ready, want_rdy);
      end
      clock_edge();
      vectors++;
      if ({bus.o_out_valid, bus.o_out_id, bus.o_out_address} !== {1'b1, 2'(k % 2), 8'(k % 2 + 1)}) begin
        miscompares++;
        $display("FAIL alternate_out[%0d]: got v=%b id=%0d addr=%h want id=%0d addr=%h", k,
                 bus.o_out_valid, bus.o_out_id, bus.o_out_address, k % 2, k % 2 + 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [OW-1:0] snap;
    snap = out_bundle;
    valid = 3'b011; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (bus.o_req_ready !== 3'b000) begin
        miscompares++;
        $display("FAIL stall_ready[%0d]: got %b want 000", k, bus.o_req_ready);
      end
      clock_edge();
      vectors++;
      if (out_bundle !== model_bundle() || out_bundle[OW-1] !== 1'b1 || out_bundle !== snap) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got %h want %h", k, out_bundle, snap);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL stall_release_ready: got %b want 001", bus.o_req_ready);
    end
    clock_edge();
    vectors++;
    if ({bus.o_out_id, bus.o_out_address} !== {2'd0, 8'h01}) begin
      miscompares++;
      $display("FAIL stall_release_out: got id=%0d addr=%h want id=0 addr=01", bus.o_out_id, bus.o_out_address);
    end
    valid = '0;
    clock_edge();
  endtask

  task automatic test_pointer_hold();
    valid = 3'b010; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      vectors++;
      if (bus.o_req_ready !== 3'b010) begin
        miscompares++;
        $display("FAIL ptr_req1_ready[%0d]: got %b want 010", k, bus.o_req_ready);
      end
      clock_edge();
    end
    valid = 3'b011;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL ptr_after_req1: got %b want 001", bus.o_req_ready);
    end
    clock_edge();
    valid = '0;
    repeat (3) clock_edge();
    valid = 3'b011;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b010) begin
      miscompares++;
      $display("FAIL ptr_idle_hold: got %b want 010", bus.o_req_ready);
    end
    clock_edge();
    valid = '0;
    clock_edge();
  endtask

  task automatic test_reset_midflight();
    valid = 3'b001; out_ready = 1'b0;
    clock_edge();
    valid = '0;
    vectors++;
    if (bus.o_out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_setup: got valid %b want 1", bus.o_out_valid);
    end
    rst = 1'b1; valid = 3'b011;
    clock_edge();
    vectors++;
    if (out_bundle !== '0 || bus.o_req_ready !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_clear: got out=%h ready=%b want 0/000", out_bundle, bus.o_req_ready);
    end
    rst = 1'b0; valid = 3'b010; out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b010) begin
      miscompares++;
      $display("FAIL midreset_req1: got %b want 010", bus.o_req_ready);
    end
    clock_edge();
    valid = 3'b011;
    #1;
    vectors++;
    if (bus.o_req_ready !== 3'b001) begin
      miscompares++;
      $display("FAIL midreset_both: got %b want 001", bus.o_req_ready);
    end
    clock_edge();
    valid = '0;
    clock_edge();
  endtask

  task automatic test_read_priority();
    logic [N-1:0] first_rdy, second_rdy, second_valid;
`ifdef REQ_RR_ARBITER_READ_PRIORITY_EN
    first_rdy = 3'b010; second_valid = 3'b001; second_rdy = 3'b001;
`else
    first_rdy = 3'b001; second_valid = 3'b010; second_rdy = 3'b010;
`endif
    do_reset();
    valid = 3'b011; cmd = 3'b010; out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.o_req_ready !== first_rdy) begin
      miscompares++;
      $display("FAIL readprio_first: got %b want %b", bus.o_req_ready, first_rdy);
    end
    clock_edge();
    valid = second_valid;
    #1;
    vectors++;
    if (bus.o_req_ready !== second_rdy) begin
      miscompares++;
      $display("FAIL readprio_second: got %b want %b", bus.o_req_ready, second_rdy);
    end
    clock_edge();
    valid = '0; cmd = '0;
    clock_edge();
  endtask

  task automatic test_random();
    logic [N-1:0] prev_rdy;
    prev_rdy = '0;
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) begin
        // Mostly honour hold-until-ready; occasionally drop or change a request.
        if (!(valid[i] && !prev_rdy[i] && $urandom_range(0, 9) != 0)) begin
          valid[i] = ($urandom_range(0, 1) == 1);
          cmd[i]   = 1'($urandom_range(0, 1));
          addr[i]  = AW'($urandom);
          data[i]  = $urandom;
        end
      end
      #1;
      prev_rdy = exp_ready();
      vectors++;
      if (bus.o_req_ready !== prev_rdy) begin
        miscompares++;
        $display("FAIL random_ready[%0d]: got %b want %b", c, bus.o_req_ready, prev_rdy);
      end
      clock_edge();
      vectors++;
      if (m_valid ? (out_bundle !== model_bundle()) : (bus.o_out_valid !== 1'b0)) begin
        miscompares++;
        $display("FAIL random_out[%0d]: got %h want %h", c, out_bundle, model_bundle());
      end
    end
    rst = 1'b0; valid = '0;
  endtask

  initial begin
    m_ptr = N - 1; m_valid = 1'b0; m_cmd = 1'b0; m_addr = '0; m_data = '0; m_id = 0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_pointer_hold();
    test_reset_midflight();
    test_read_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
